// File: rtl/ram_stream_reader_pkg.sv
// Shared definitions for the frame-RAM stream reader.
//   ADDR_W_DEF / DATA_W_DEF : default RAM address and word widths
//   FRAME_LEN_VGA           : words in a 640x480 frame
//   state_e                 : reader FSM encoding
package ram_stream_reader_pkg;

   localparam int unsigned ADDR_W_DEF    = 20;
   localparam int unsigned DATA_W_DEF    = 12;
   localparam int unsigned FRAME_LEN_VGA = 307200;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StRun   = 2'd1,
      StDrain = 2'd2
   } state_e;

endpackage

// File: rtl/stream_fifo2.sv
// Two-entry synchronous FIFO holding {sof, eof, data} words for the pixel stream.
// Ports:
//   clk_d  : clock, rising edge
//   rst    : synchronous active-high reset, empties the FIFO
//   push   : write wdata this cycle
//   pop    : remove the head entry this cycle
//   wdata  : entry to write
//   rdata  : head entry (meaningful when count != 0)
//   count  : number of stored entries, 0..2
module stream_fifo2 #(
   parameter int unsigned WIDTH = 14
) (
   input  logic             clk_d,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic [1:0]       count
);

   logic [WIDTH-1:0] mem_q [2];
   logic             wr_ptr_q;
   logic             rd_ptr_q;
   logic [1:0]       count_q;
   logic             push_ok;
   logic             pop_ok;

   // A push into a full FIFO is only legal when the head leaves in the same cycle.
   assign pop_ok  = pop && (count_q != 2'd0);
   assign push_ok = push && ((count_q != 2'd2) || pop_ok);

   always_ff @(posedge clk_d) begin
      if (rst) begin
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata;
            wr_ptr_q        <= ~wr_ptr_q;
         end
         if (pop_ok) begin
            rd_ptr_q <= ~rd_ptr_q;
         end
         count_q <= count_q + 2'(push_ok) - 2'(pop_ok);
      end
   end

   assign rdata = mem_q[rd_ptr_q];
   assign count = count_q;

endmodule

// File: rtl/ram_stream_reader.sv
// Read-side master for a 1-cycle registered-read RAM. On start it sweeps FRAME_LEN consecutive
// words from base_addr and presents them as a valid/ready pixel stream with sof/eof markers.
// Ports:
//   clk_d      : clock, rising edge
//   rst        : synchronous active-high reset
//   start      : one-cycle frame request, only honoured while idle
//   base_addr  : first RAM address, captured on an accepted start
//   ram_addr   : RAM address (wraps modulo 2^ADDR_W)
//   ram_we     : RAM write enable, tied low
//   ram_din    : RAM write data, tied to zero
//   ram_dout   : RAM read data, valid the cycle after the address
//   pix_data   : stream data
//   pix_valid  : stream valid
//   pix_ready  : consumer ready; valid && ready is a transfer
//   pix_sof    : first word of the frame
//   pix_eof    : last word of the frame
//   busy       : frame in progress
//   done       : one-cycle pulse after the eof transfer
module ram_stream_reader
   import ram_stream_reader_pkg::*;
#(
   parameter int unsigned ADDR_W    = ADDR_W_DEF,
   parameter int unsigned DATA_W    = DATA_W_DEF,
   parameter int unsigned FRAME_LEN = FRAME_LEN_VGA
) (
   input  logic              clk_d,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_we,
   output logic [DATA_W-1:0] ram_din,
   input  logic [DATA_W-1:0] ram_dout,
   output logic [DATA_W-1:0] pix_data,
   output logic              pix_valid,
   input  logic              pix_ready,
   output logic              pix_sof,
   output logic              pix_eof,
   output logic              busy,
   output logic              done
);

   localparam int unsigned     ENTRY_W  = DATA_W + 2;
   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(FRAME_LEN - 1);

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   base_q;
   logic [ADDR_W-1:0]   idx_q;
   logic [ADDR_W-1:0]   last_addr_q;
   logic                inflight_q;
   logic [1:0]          tag_q;        // {sof, eof} of the word in the RAM pipe
   logic                done_q;

   logic [1:0]          count;
   logic [ENTRY_W-1:0]  head;
   logic                accept;
   logic                pop;
   logic                issue;
   logic [2:0]          pending;
   logic                head_sof;
   logic                head_eof;

   // The done cycle is already idle but must not start a new frame.
   assign accept = (state_q == StIdle) && start && !done_q;
   assign pop    = pix_valid && pix_ready;

   // Words owed to the FIFO: stored + still in the RAM pipe - leaving now. Keeping this below
   // two before issuing means the 2-entry FIFO can never overflow, yet sustains 1 word/cycle.
   assign pending = 3'(count) + 3'(inflight_q) - 3'(pop);
   assign issue   = (state_q == StRun) && (pending < 3'd2);

   // Address is shown combinationally on the issue cycle and held otherwise.
   assign ram_addr = issue ? (base_q + idx_q) : last_addr_q;
   assign ram_we   = 1'b0;
   assign ram_din  = '0;

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (accept) state_d = StRun;
         StRun:   if (issue && (idx_q == LAST_IDX)) state_d = StDrain;
         StDrain: if (pop && head_eof) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_d) begin
      if (rst) begin
         state_q     <= StIdle;
         base_q      <= '0;
         idx_q       <= '0;
         last_addr_q <= '0;
         inflight_q  <= 1'b0;
         tag_q       <= 2'b00;
         done_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         inflight_q <= issue;
         done_q     <= (state_q == StDrain) && pop && head_eof;
         if (accept) begin
            base_q <= base_addr;
            idx_q  <= '0;
         end
         if (issue) begin
            idx_q       <= idx_q + ADDR_W'(1);
            last_addr_q <= ram_addr;
            tag_q       <= {idx_q == '0, idx_q == LAST_IDX};
         end
      end
   end

   stream_fifo2 #(
      .WIDTH (ENTRY_W)
   ) u_fifo (
      .clk_d (clk_d),
      .rst   (rst),
      .push  (inflight_q),
      .pop   (pop),
      .wdata ({tag_q, ram_dout}),
      .rdata (head),
      .count (count)
   );

   assign head_sof  = head[ENTRY_W-1];
   assign head_eof  = head[ENTRY_W-2];
   assign pix_valid = (count != 2'd0);
   assign pix_data  = pix_valid ? head[DATA_W-1:0] : '0;
   assign pix_sof   = pix_valid && head_sof;
   assign pix_eof   = pix_valid && head_eof;
   assign busy      = (state_q != StIdle);
   assign done      = done_q;

endmodule

// File: tb/tb_ram_stream_reader.sv
// Bench for ram_stream_reader: two instances (FRAME_LEN 4 and 1) share stimulus; a frame-level
// model predicts every transferred word, the markers, busy, done and start-to-data latency.
module tb_ram_stream_reader;

   localparam int AW  = 20;
   localparam int DW  = 12;
   localparam int FL0 = 4;
   localparam int FL1 = 1;

   logic clk_d;
   initial clk_d = 1'b0;
   always #5 clk_d = ~clk_d;

   logic                  rst, start, pix_ready;
   logic [AW-1:0]         base_addr;
   logic [1:0][AW-1:0]    ram_addr;
   logic [1:0]            ram_we;
   logic [1:0][DW-1:0]    ram_din, ram_dout, pix_data;
   logic [1:0]            pix_valid, pix_sof, pix_eof, busy, done;

   ram_stream_reader #(.ADDR_W(AW), .DATA_W(DW), .FRAME_LEN(FL0)) dut0 (
      .clk_d(clk_d), .rst(rst), .start(start), .base_addr(base_addr),
      .ram_addr(ram_addr[0]), .ram_we(ram_we[0]), .ram_din(ram_din[0]),
      .ram_dout(ram_dout[0]), .pix_data(pix_data[0]), .pix_valid(pix_valid[0]),
      .pix_ready(pix_ready), .pix_sof(pix_sof[0]), .pix_eof(pix_eof[0]),
      .busy(busy[0]), .done(done[0])
   );

   ram_stream_reader #(.ADDR_W(AW), .DATA_W(DW), .FRAME_LEN(FL1)) dut1 (
      .clk_d(clk_d), .rst(rst), .start(start), .base_addr(base_addr),
      .ram_addr(ram_addr[1]), .ram_we(ram_we[1]), .ram_din(ram_din[1]),
      .ram_dout(ram_dout[1]), .pix_data(pix_data[1]), .pix_valid(pix_valid[1]),
      .pix_ready(pix_ready), .pix_sof(pix_sof[1]), .pix_eof(pix_eof[1]),
      .busy(busy[1]), .done(done[1])
   );

   // RAM contents: 0x100 + addr for low addresses, upper address bits folded in.
   function automatic logic [DW-1:0] word(input logic [AW-1:0] a);
      return (12'h100 + a[11:0]) ^ {4'h0, a[19:12]};
   endfunction

   always @(posedge clk_d) begin
      for (int i = 0; i < 2; i++) ram_dout[i] <= word(ram_addr[i]);
   end

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   bit            act [2];
   bit            done_due [2];
   bit            stall [2];
   bit            exp_reset;
   logic [AW-1:0] mbase [2];
   int            k [2];
   int            lat [2];
   logic [DW+1:0] log_w [2][16];
   int            log_c [2][16];
   int            log_n [2];
   int            done_n [2];
   int            done_c [2];

   function automatic int fl(input int i);
      return (i == 0) ? FL0 : FL1;
   endfunction

   task automatic chk(input string name, input int i, input logic [31:0] got,
                      input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s[%0d] cycle %0d: got %0h want %0h", name, i, cyc, got, want);
      end
   endtask

   task automatic monitor();
      for (int i = 0; i < 2; i++) begin
         bit            was_act, dn;
         logic [AW-1:0] a;
         if (exp_reset) begin
            chk("rst_valid", i, 32'(pix_valid[i]), 0);
            chk("rst_addr", i, 32'(ram_addr[i]), 0);
            chk("rst_data", i, 32'({pix_sof[i], pix_eof[i], pix_data[i]}), 0);
         end
         chk("busy", i, 32'(busy[i]), 32'(act[i]));
         chk("done", i, 32'(done[i]), 32'(done_due[i]));
         if (done[i]) begin
            done_n[i]++;
            done_c[i] = cyc;
         end
         chk("we_din", i, 32'({ram_we[i], ram_din[i]}), 0);
         chk("valid_idle", i, 32'(pix_valid[i] & ~act[i]), 0);
         if (lat[i] >= 0) begin
            lat[i]++;
            if (lat[i] < 3) chk("early_valid", i, 32'(pix_valid[i]), 0);
            else begin
               chk("first_valid", i, 32'(pix_valid[i]), 1);
               lat[i] = -1;
            end
         end
         if (stall[i]) chk("held_valid", i, 32'(pix_valid[i]), 1);
         if (pix_valid[i] && act[i]) begin
            a = mbase[i] + AW'(k[i]);
            chk("data", i, 32'(pix_data[i]), 32'(word(a)));
            chk("sof", i, 32'(pix_sof[i]), 32'(k[i] == 0));
            chk("eof", i, 32'(pix_eof[i]), 32'(k[i] == fl(i) - 1));
         end
         stall[i] = pix_valid[i] && !pix_ready;

         was_act = act[i];
         dn      = 1'b0;
         if (pix_valid[i] && pix_ready && act[i]) begin
            if (log_n[i] < 16) begin
               log_w[i][log_n[i]] = {pix_sof[i], pix_eof[i], pix_data[i]};
               log_c[i][log_n[i]] = cyc;
               log_n[i]++;
            end
            k[i]++;
            if (k[i] == fl(i)) begin
               act[i] = 1'b0;
               dn     = 1'b1;
            end
         end
         if (start && !was_act && !done_due[i]) begin
            act[i]   = 1'b1;
            mbase[i] = base_addr;
            k[i]     = 0;
            log_n[i] = 0;
            lat[i]   = 0;
         end
         done_due[i] = dn;
         if (rst) begin
            act[i]      = 1'b0;
            done_due[i] = 1'b0;
            stall[i]    = 1'b0;
            k[i]        = 0;
            lat[i]      = -1;
         end
      end
      exp_reset = rst;
   endtask

   task automatic cycle();
      @(negedge clk_d);
      monitor();
      @(posedge clk_d);
      #1;
      cyc++;
   endtask

   task automatic start_frame(input logic [AW-1:0] b);
      base_addr = b;
      start     = 1'b1;
      cycle();
      start     = 1'b0;
   endtask

   // mode 0: ready held high, 1: ready pattern 1,0,0 repeating, 2: random ready.
   task automatic run_idle(input int mode);
      int j;
      j = 0;
      while ((act[0] || act[1] || done_due[0] || done_due[1]) && j < 200) begin
         if (mode == 0) pix_ready = 1'b1;
         else if (mode == 1) pix_ready = (j % 3 == 0);
         else pix_ready = 1'($urandom_range(0, 1));
         cycle();
         j++;
      end
      chk("frame_timeout", 0, 32'(busy), 0);
   endtask

   task automatic expect4(input string name, input logic [DW-1:0] w0, input logic [DW-1:0] w1,
                          input logic [DW-1:0] w2, input logic [DW-1:0] w3);
      chk({name, "_n"}, 0, 32'(log_n[0]), 4);
      chk({name, "_w0"}, 0, 32'(log_w[0][0]), 32'({2'b10, w0}));
      chk({name, "_w1"}, 0, 32'(log_w[0][1]), 32'({2'b00, w1}));
      chk({name, "_w2"}, 0, 32'(log_w[0][2]), 32'({2'b00, w2}));
      chk({name, "_w3"}, 0, 32'(log_w[0][3]), 32'({2'b01, w3}));
      chk({name, "_n"}, 1, 32'(log_n[1]), 1);
      chk({name, "_single"}, 1, 32'(log_w[1][0]), 32'({2'b11, w0}));
   endtask

   initial begin
      for (int i = 0; i < 2; i++) begin
         act[i] = 1'b0; done_due[i] = 1'b0; stall[i] = 1'b0; k[i] = 0; lat[i] = -1;
         log_n[i] = 0; done_n[i] = 0; done_c[i] = 0; mbase[i] = '0;
      end
      rst = 1'b1; start = 1'b0; pix_ready = 1'b1; base_addr = '0;
      @(posedge clk_d);
      #1;
      exp_reset = 1'b1;
      cycle();
      rst = 1'b0;
      cycle();

      // Basic frame, ready held high.
      start_frame(20'h1);
      run_idle(0);
      expect4("basic", 12'h101, 12'h102, 12'h103, 12'h104);
      chk("basic_span", 0, 32'(log_c[0][3] - log_c[0][0]), 3);
      chk("basic_done", 0, 32'(done_c[0] - log_c[0][3]), 1);

      // Ready toggling 1,0,0.
      start_frame(20'h1);
      run_idle(1);
      expect4("toggle", 12'h101, 12'h102, 12'h103, 12'h104);

      // Address wrap past all-ones.
      pix_ready = 1'b1;
      start_frame(20'hFFFFF);
      chk("wrap_a0", 0, 32'(ram_addr[0]), 32'h000FFFFF);
      cycle();
      chk("wrap_a1", 0, 32'(ram_addr[0]), 32'h0);
      cycle();
      chk("wrap_a2", 0, 32'(ram_addr[0]), 32'h1);
      run_idle(0);
      expect4("wrap", 12'h000, 12'h100, 12'h101, 12'h102);

      // Second start mid-frame is ignored.
      done_n[0] = 0; done_n[1] = 0;
      start_frame(20'h1);
      cycle();
      start_frame(20'h5);
      run_idle(0);
      expect4("restart", 12'h101, 12'h102, 12'h103, 12'h104);
      chk("restart_dones", 0, 32'(done_n[0]), 1);
      chk("restart_dones", 1, 32'(done_n[1]), 1);

      // Reset right after the second transfer, then a clean frame.
      start_frame(20'h1);
      for (int j = 0; j < 20 && log_n[0] < 2; j++) cycle();
      chk("rst_reached", 0, 32'(log_n[0]), 2);
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      cycle();
      start_frame(20'h1);
      run_idle(0);
      expect4("after_rst", 12'h101, 12'h102, 12'h103, 12'h104);

      // Sustained backpressure: two words buffered, address holds.
      pix_ready = 1'b0;
      start_frame(20'h300);
      for (int j = 0; j < 8; j++) cycle();
      chk("bp_addr", 0, 32'(ram_addr[0]), 32'h301);
      chk("bp_addr", 1, 32'(ram_addr[1]), 32'h300);
      chk("bp_none", 0, 32'(log_n[0]), 0);
      for (int j = 0; j < 3; j++) cycle();
      chk("bp_hold", 0, 32'(ram_addr[0]), 32'h301);
      run_idle(0);
      expect4("bp", 12'h400, 12'h401, 12'h402, 12'h403);

      // Random traffic, starts and occasional resets.
      for (int j = 0; j < 3000; j++) begin
         base_addr = AW'($urandom);
         start     = ($urandom_range(0, 4) == 0);
         pix_ready = ($urandom_range(0, 9) < 6);
         rst       = ($urandom_range(0, 99) == 0);
         cycle();
      end
      start = 1'b0;
      rst   = 1'b0;
      run_idle(2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
